// File: rtl/waterfall_pkg.sv
// Shared constants, FSM state type and RAM address helper for the waterfall framebuffer.
// Latency: none, everything here is constant or combinational.
// Backpressure: not applicable.
package waterfall_pkg;

    localparam int COLS   = 320;
    localparam int ROWS   = 240;
    localparam int PIX_W  = 8;
    localparam int ADDR_W = 17;
    localparam int COL_W  = 9;
    localparam int ROW_W  = 8;
    localparam int NPIX   = COLS * ROWS;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    // col + row*320, with the multiply built from two shifts (256 + 64)
    function automatic logic [ADDR_W-1:0] row_addr(input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] col);
        logic [ADDR_W-1:0] r;
        r = ADDR_W'(row);
        return (r << 8) + (r << 6) + ADDR_W'(col);
    endfunction

endpackage

// File: rtl/waterfall_fb_ctrl_fifo.sv
// Generic synchronous FIFO holding ADC samples until the RAM port is free.
// Latency: an entry pushed in cycle c is visible on dout in cycle c+1.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
module wf_sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr[AW-1:0]];

    // Storage needs no reset; only the pointers define what is valid
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= din;
        end
    end

    // Pointer advance; reset discards all contents
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rptr <= rptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/waterfall_fb_ctrl.sv
// Waterfall framebuffer controller: shares one RAM port between LCD scanout and ADC writes (WF_CLEAR_EN adds a zero-fill sweep after reset).
// Latency: x/y in cycle c -> RAM read data in c+1 -> pix_data in c+2; a queued sample is written on the first non-visible cycle.
// Backpressure: scanout always wins; samples wait in a small FIFO, and a sample arriving with the FIFO full and no drain is dropped (sticky overflow).
module waterfall_fb_ctrl
    import waterfall_pkg::*;
#(
    parameter int SAMPLE_W   = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                visible,
    input  logic [COL_W-1:0]    x,
    input  logic [ROW_W-1:0]    y,
    input  logic                frame_start,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_data,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [PIX_W-1:0]    ram_wdata,
    output logic                ram_we,
    input  logic [PIX_W-1:0]    ram_rdata,
    output logic [PIX_W-1:0]    pix_data,
    output logic                busy,
    output logic                overflow,
    input  logic                ovf_clr
);

    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [ROW_W:0]    ROWS_X   = (ROW_W+1)'(ROWS);

    state_t            state;
    logic [COL_W-1:0]  wr_col;
    logic [ROW_W-1:0]  wr_row;
    logic [ROW_W-1:0]  wr_row_nxt;
    logic [ROW_W-1:0]  row_base;
    logic [ROW_W:0]    rd_row_sum;
    logic [ROW_W-1:0]  rd_row;
    logic              col_wrap;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [PIX_W-1:0]  fifo_dout;
    logic              sample_drop;
    logic              we_int;
    logic              vis_d1;
    logic              unused_lsbs;

    // Only the top PIX_W bits of a sample ever reach the RAM, so only those are queued
    assign unused_lsbs = ^sample_data[SAMPLE_W-PIX_W-1:0];

    // Drain only in RUN and only while scanout is not using the RAM
    assign fifo_pop    = (state == ST_RUN) && !visible && !fifo_empty;
    assign sample_drop = sample_valid && fifo_full && !fifo_pop;

    wf_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIX_W)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (sample_valid),
        .pop    (fifo_pop),
        .din    (sample_data[SAMPLE_W-1 -: PIX_W]),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Display row is offset by row_base so the newest row lands at the bottom
    assign rd_row_sum = {1'b0, y} + {1'b0, row_base};
    assign rd_row     = (rd_row_sum >= ROWS_X) ? ROW_W'(rd_row_sum - ROWS_X)
                                               : rd_row_sum[ROW_W-1:0];

    assign col_wrap   = (wr_col == COL_LAST);
    assign wr_row_nxt = (fifo_pop && col_wrap) ? ((wr_row == ROW_LAST) ? '0 : wr_row + ROW_W'(1))
                                               : wr_row;

`ifdef WF_CLEAR_EN
    logic [ADDR_W-1:0] clr_addr;

    // Clear sweep: one zero write per cycle, then hand the RAM to the sample path
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_CLEAR;
            busy     <= 1'b1;
            clr_addr <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clr_addr == ADDR_W'(NPIX - 1)) begin
                        state <= ST_RUN;
                        busy  <= 1'b0;
                    end else begin
                        clr_addr <= clr_addr + ADDR_W'(1);
                    end
                end
                default: begin
                    state <= ST_RUN;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
`else
    assign state = ST_RUN;
    assign busy  = 1'b0;
`endif

    // RAM port arbitration: clear sweep, then sample write, otherwise scanout read
    always_comb begin
        ram_addr  = row_addr(rd_row, x);
        ram_wdata = '0;
        we_int    = 1'b0;
`ifdef WF_CLEAR_EN
        if (state == ST_CLEAR) begin
            ram_addr = clr_addr;
            we_int   = 1'b1;
        end else
`endif
        if (fifo_pop) begin
            ram_addr  = row_addr(wr_row, wr_col);
            ram_wdata = fifo_dout;
            we_int    = 1'b1;
        end
    end

    // Hold the write strobe off for as long as reset is asserted
    assign ram_we = we_int && resetn;

    // Write cursor advance and tear-free display base update at frame start
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_col   <= '0;
            wr_row   <= '0;
            row_base <= ROW_W'(1);
        end else begin
            if (fifo_pop) begin
                wr_col <= col_wrap ? '0 : wr_col + COL_W'(1);
            end
            wr_row <= wr_row_nxt;
            if (frame_start) begin
                row_base <= (wr_row_nxt == ROW_LAST) ? '0 : wr_row_nxt + ROW_W'(1);
            end
        end
    end

    // Scanout pipeline: blank the pixel outside the active region and during clear
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vis_d1   <= 1'b0;
            pix_data <= '0;
        end else begin
            vis_d1   <= visible;
            pix_data <= (vis_d1 && !busy) ? ram_rdata : '0;
        end
    end

    // Sticky drop flag; a drop in the same cycle as a clear wins
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow <= 1'b0;
        end else if (sample_drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_waterfall_fb_ctrl.sv
// Testbench for waterfall_fb_ctrl: directed scenarios plus random traffic checked against a queue-based model.
// Latency: model expects writes on the first non-visible cycle after queueing, pixels two cycles after x/y.
// Backpressure: model drops a sample when four are queued and no drain happens that cycle.
module tb_waterfall_fb_ctrl;
    import waterfall_pkg::*;

    localparam int NP = COLS * ROWS;
    localparam int FD = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        visible = 1'b0;
    logic [8:0]  x = '0;
    logic [7:0]  y = '0;
    logic        frame_start = 1'b0;
    logic        sample_valid = 1'b0;
    logic [11:0] sample_data = '0;
    logic        ovf_clr = 1'b0;
    logic [16:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_rdata = '0;
    logic [7:0]  pix_data;
    logic        busy;
    logic        overflow;

    waterfall_fb_ctrl #(.SAMPLE_W(12), .FIFO_DEPTH(FD)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .visible      (visible),
        .x            (x),
        .y            (y),
        .frame_start  (frame_start),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_we       (ram_we),
        .ram_rdata    (ram_rdata),
        .pix_data     (pix_data),
        .busy         (busy),
        .overflow     (overflow),
        .ovf_clr      (ovf_clr)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM: read data one cycle after the address
    logic [7:0] ram [NP];
    always @(posedge clk) begin
        if (ram_we && int'(ram_addr) < NP) ram[ram_addr] <= ram_wdata;
        ram_rdata <= (int'(ram_addr) < NP) ? ram[ram_addr] : 8'h00;
    end

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state
    logic [7:0] exp_mem [NP];
    int q[$];
    int n_wr;
    int rb;
    bit m_ovf;
    int p1, p2;
    int we_seen = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        n_wr  = 0;
        rb    = 1;
        m_ovf = 1'b0;
        p1    = 0;
        p2    = 0;
    endtask

    task automatic do_reset(input int hold);
        int clr_cnt;
        int clr_bad;
        @(negedge clk);
        resetn = 1'b0;
        visible = 1'b0; frame_start = 1'b0; sample_valid = 1'b0; ovf_clr = 1'b0;
        #1;
        chk_eq("rst_ram_we", ram_we, 0);
        chk_eq("rst_pix", pix_data, 0);
        chk_eq("rst_ovf", overflow, 0);
`ifdef WF_CLEAR_EN
        chk_eq("rst_busy", busy, 1);
`else
        chk_eq("rst_busy", busy, 0);
`endif
        repeat (hold) @(negedge clk);
        resetn = 1'b1;
        model_reset();
`ifdef WF_CLEAR_EN
        clr_cnt = 0;
        clr_bad = 0;
        #1;
        while (busy === 1'b1 && clr_cnt < NP + 8) begin
            if (ram_we !== 1'b1 || ram_wdata !== 8'h00 || int'(ram_addr) != clr_cnt) clr_bad++;
            clr_cnt++;
            @(negedge clk);
            #1;
        end
        chk_eq("clear_cycles", clr_cnt, NP);
        chk_eq("clear_writes", clr_bad, 0);
        for (int i = 0; i < NP; i++) exp_mem[i] = 8'h00;
`endif
    endtask

    // One clock of stimulus; outputs checked against the model before the edge
    task automatic step(input bit vis, input int xx, input int yy, input bit fs,
                        input bit sv, input int sd, input bit oc);
        bit pop;
        bit drop;
        int ra;
        int wa;
        int sdm;
        @(negedge clk);
        visible = vis; x = 9'(xx); y = 8'(yy); frame_start = fs;
        sample_valid = sv; sample_data = 12'(sd); ovf_clr = oc;
        #1;
        sdm = sd & 'hFFF;
        pop = !vis && (q.size() > 0);
        ra  = xx + ((yy + rb) % ROWS) * COLS;
        wa  = n_wr % NP;
        if (ram_we === 1'b1) we_seen++;
        chk_eq("ram_we", ram_we, pop);
        if (pop) begin
            chk_eq("wr_addr", ram_addr, wa);
            chk_eq("wr_data", ram_wdata, (q[0] >> 4) & 255);
        end else if (vis) begin
            chk_eq("rd_addr", ram_addr, ra);
        end
        chk_eq("pix_data", pix_data, p2);
        chk_eq("overflow", overflow, m_ovf);
        chk_eq("busy", busy, 0);
        if (pop) begin
            exp_mem[wa] = 8'(q[0] >> 4);
            void'(q.pop_front());
            n_wr++;
        end
        drop = 1'b0;
        if (sv) begin
            if (q.size() < FD) q.push_back(sdm);
            else drop = 1'b1;
        end
        if (drop) m_ovf = 1'b1;
        else if (oc) m_ovf = 1'b0;
        if (fs) rb = ((n_wr / COLS) % ROWS + 1) % ROWS;
        p2 = p1;
        p1 = vis ? int'(exp_mem[ra]) : 0;
    endtask

    task automatic idle();
        step(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        int we0;
        int s0;
        for (int i = 0; i < NP; i++) begin
            ram[i] = 8'h00;
            exp_mem[i] = 8'h00;
        end
        model_reset();

        do_reset(3);

        // Three samples land at consecutive addresses
        step(1'b0, 0, 0, 1'b0, 1'b1, 'h000, 1'b0);
        step(1'b0, 0, 0, 1'b0, 1'b1, 'h010, 1'b0);
        step(1'b0, 0, 0, 1'b0, 1'b1, 'h020, 1'b0);
        repeat (3) idle();
        chk_eq("t2_ram1", ram[1], 8'h01);
        chk_eq("t2_ram2", ram[2], 8'h02);

        // Visible blocks draining; fifth sample overflows
        we0 = we_seen;
        for (int i = 0; i < 5; i++)
            step(1'b1, $urandom_range(0, COLS-1), $urandom_range(0, ROWS-1), 1'b0, 1'b1, $urandom, 1'b0);
        chk_eq("t3_no_we", we_seen - we0, 0);
        idle();
        chk_eq("t3_ovf_set", overflow, 1);
        repeat (5) idle();
        chk_eq("t3_writes", we_seen - we0, 4);
        step(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b1);
        idle();
        chk_eq("t3_ovf_clr", overflow, 0);

        // One full row, frame_start on the wrapping write, then scan the bottom-offset row
        do_reset(2);
        s0 = 'h800 | ($urandom & 'h7FF);
        step(1'b0, 0, 0, 1'b0, 1'b1, s0, 1'b0);
        for (int i = 1; i < COLS; i++) step(1'b0, 0, 0, 1'b0, 1'b1, $urandom, 1'b0);
        step(1'b0, 0, 0, 1'b1, 1'b0, 0, 1'b0);
        step(1'b1, 0, 238, 1'b0, 1'b0, 0, 1'b0);
        chk_eq("t4_rd_addr", ram_addr, 0);
        idle();
        idle();
        chk_eq("t4_pix", pix_data, (s0 >> 4) & 255);

        // Full frame of samples, then the next one wraps back to address 0
        do_reset(2);
        for (int i = 0; i < NP; i++) step(1'b0, 0, 0, 1'b0, 1'b1, $urandom, 1'b0);
        idle();
        step(1'b0, 0, 0, 1'b0, 1'b1, 'hABC, 1'b0);
        idle();
        chk_eq("t5_wrap_we", ram_we, 1);
        chk_eq("t5_wrap_addr", ram_addr, 0);

        // Reset while the FIFO still holds three entries
        for (int i = 0; i < 4; i++)
            step(1'b1, $urandom_range(0, COLS-1), $urandom_range(0, ROWS-1), 1'b0, 1'b1, $urandom, 1'b0);
        idle();
        do_reset(2);
        idle();
        idle();
        step(1'b0, 0, 0, 1'b0, 1'b1, 'h5A0, 1'b0);
        idle();
        chk_eq("t6_first_we", ram_we, 1);
        chk_eq("t6_first_addr", ram_addr, 0);
        chk_eq("t6_first_data", ram_wdata, 8'h5A);

        // Random mix of scanout, samples, frame starts and overflow clears
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 3) != 0,
                 $urandom_range(0, COLS-1), $urandom_range(0, ROWS-1),
                 ($urandom % 40) == 0,
                 ($urandom % 2) == 0, $urandom,
                 ($urandom % 16) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
